// File: rtl/trivium_xor_stage.sv
// Packs Trivium keystream bits into words and XORs them with plaintext.
// Define TRIV_XOR_LSB_FIRST_EN to pack the first keystream bit into bit 0.
module trivium_xor_stage #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LENW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LENW-1:0] len,
  input  logic            ks_bit,
  input  logic            ks_valid,
  output logic            ks_ready,
  input  logic [W-1:0]    pt_data,
  input  logic            pt_valid,
  output logic            pt_ready,
  output logic [W-1:0]    ct_data,
  output logic            ct_valid,
  input  logic            ct_ready,
  output logic            busy,
  output logic            done
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;

  logic [LENW-1:0]   r_n_words;
  logic [LENW:0]     r_bits_lim;
  logic [LENW:0]     r_bits_taken;
  logic [LENW-1:0]   r_out_cnt;

  logic [PW-1:0]     r_pack_cnt;
  logic [W-1:0]      r_pack;
  logic [W-1:0]      w_pack_nx;

  logic [W-1:0]      r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic [W-1:0]      r_ct_data;
  logic              r_ct_valid;

  logic [LENW-1:0]   w_n_words;
  logic [LENW:0]     w_bits_lim;
  logic              w_run;
  logic              w_full;
  logic              w_empty;
  logic              w_pack_last;
  logic              w_ks_fire;
  logic              w_push;
  logic              w_pop;
  logic              w_ct_fire;
  logic              w_last;
  logic              w_launch;

  assign w_n_words  = len / LENW'(W);
  assign w_bits_lim = (LENW+1)'(w_n_words) * (LENW+1)'(W);

  assign w_run       = (r_state == S_RUN);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pack_last = (r_pack_cnt == PW'(W-1));

  assign ks_ready = w_run
                 && (r_bits_taken < r_bits_lim)
                 && !(w_pack_last && w_full);
  assign pt_ready = w_run && !w_empty
                 && (!r_ct_valid || ct_ready);

  assign w_ks_fire = ks_valid && ks_ready;
  assign w_push    = w_ks_fire && w_pack_last;
  assign w_pop     = pt_valid && pt_ready;
  assign w_ct_fire = r_ct_valid && ct_ready;
  assign w_last    = w_ct_fire
                  && (r_out_cnt == r_n_words - 1'b1);
  assign w_launch  = (r_state == S_IDLE) && start;

`ifdef TRIV_XOR_LSB_FIRST_EN
  assign w_pack_nx = {ks_bit, r_pack[W-1:1]};
`else
  assign w_pack_nx = {r_pack[W-2:0], ks_bit};
`endif

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_n_words == '0) w_state_nx = S_DONE;
          else                 w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nx = S_DONE;
      end
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_pack_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_n_words    <= '0;
      r_bits_lim   <= '0;
      r_bits_taken <= '0;
      r_out_cnt    <= '0;
      r_pack_cnt   <= '0;
      r_pack       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_ct_data    <= '0;
      r_ct_valid   <= 1'b0;
    end else if (w_launch) begin
      r_n_words    <= w_n_words;
      r_bits_lim   <= w_bits_lim;
      r_bits_taken <= '0;
      r_out_cnt    <= '0;
      r_pack_cnt   <= '0;
      r_pack       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_ct_valid   <= 1'b0;
    end else begin
      if (w_ks_fire) begin
        r_bits_taken <= r_bits_taken + 1'b1;
        r_pack       <= w_pack_nx;
        r_pack_cnt   <= w_pack_last ? '0
                      : r_pack_cnt + 1'b1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new word may replace one leaving in the same cycle.
      if (w_pop) begin
        r_ct_data  <= pt_data ^ r_mem[r_rptr];
        r_ct_valid <= 1'b1;
      end else if (w_ct_fire) begin
        r_ct_valid <= 1'b0;
      end
      if (w_ct_fire) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  assign ct_data  = r_ct_data;
  assign ct_valid = r_ct_valid;
  assign busy     = w_run;
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_trivium_xor_stage.sv
// Directed bench for trivium_xor_stage.
// Covers framing, backpressure, remainder, reset abort, start masking.
module tb_trivium_xor_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic        ks_bit;
  logic        ks_valid;
  logic        ks_ready;
  logic [7:0]  pt_data;
  logic        pt_valid;
  logic        pt_ready;
  logic [7:0]  ct_data;
  logic        ct_valid;
  logic        ct_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  int nacc, nct, ndone, busy_seen, ksr_seen;
  int first_done, hold_bad, nacc_bp, ksr_bp;
  logic [7:0] ctw [16];

`ifdef TRIV_XOR_LSB_FIRST_EN
  localparam logic [7:0] BASIC_CT = 8'hB2;
`else
  localparam logic [7:0] BASIC_CT = 8'h4D;
`endif

  always #5 clk = ~clk;

  trivium_xor_stage #(.W(8), .DEPTH(4), .LENW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .ks_bit   (ks_bit),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .pt_data  (pt_data),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .ct_data  (ct_data),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    ks_bit   = 1'b0;
    ks_valid = 1'b0;
    pt_valid = 1'b0;
    pt_data  = '0;
    ct_ready = 1'b0;
  endtask

  // Entered and left just after a rising edge.
  task automatic run(input int lenv,
                     input logic [63:0] kb,
                     input int nav,
                     input logic [7:0] ptv,
                     input int ctr_from,
                     input int ncyc,
                     input int restart_at,
                     input int abort_ct);
    logic [7:0] held;
    bit held_set;
    held_set   = 1'b0;
    held       = '0;
    nacc       = 0;
    nct        = 0;
    ndone      = 0;
    busy_seen  = 0;
    ksr_seen   = 0;
    first_done = -1;
    hold_bad   = 0;
    nacc_bp    = -1;
    ksr_bp     = -1;
    start = 1'b1;
    len   = 16'(lenv);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      ks_valid = (nacc < nav);
      ks_bit   = kb[nacc % 64];
      pt_valid = 1'b1;
      pt_data  = ptv;
      ct_ready = (c >= ctr_from);
      start    = (c == restart_at);
      len      = (c == restart_at) ? 16'd64 : 16'(lenv);
      #1;
      if (busy) busy_seen = 1;
      if (ks_ready) ksr_seen = 1;
      if (done) begin
        if (first_done < 0) first_done = c;
        ndone++;
      end
      if (c == ctr_from - 1) begin
        nacc_bp = nacc;
        ksr_bp  = int'(ks_ready);
      end
      if (ct_valid && !ct_ready) begin
        if (!held_set) begin
          held     = ct_data;
          held_set = 1'b1;
        end else if (ct_data !== held) begin
          hold_bad++;
        end
      end
      if (ks_valid && ks_ready) nacc++;
      if (ct_valid && ct_ready && nct < 16) begin
        ctw[nct] = ct_data;
        nct++;
      end
      if (abort_ct > 0 && nct == abort_ct) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctd"}, 32'(ct_data), 32'h0);
    chk({tag, "_ctv"}, 32'(ct_valid), 32'h0);
    chk({tag, "_ksr"}, 32'(ks_ready), 32'h0);
    chk({tag, "_ptr"}, 32'(pt_ready), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    idle_inputs();
    len   = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("rst");
    reset = 1'b1;

    // bits 1,0,1,1,0,0,1,0 in stream order
    run(8, 64'h4D, 8, 8'hFF, 0, 30, -1, 0);
    chk("basic_nct", nct, 1);
    chk("basic_ct", 32'(ctw[0]), 32'(BASIC_CT));
    chk("basic_acc", nacc, 8);
    chk("basic_done", ndone, 1);

    run(0, 64'h0, 8, 8'h00, 0, 10, -1, 0);
    chk("zero_ksr", ksr_seen, 0);
    chk("zero_busy", busy_seen, 0);
    chk("zero_done", ndone, 1);
    chk("zero_when", 32'(first_done <= 1), 1);

    run(64, 64'hFF00FF00FF00FF00, 64, 8'h5A,
        100, 200, -1, 0);
    chk("bp_acc", nacc_bp, 47);
    chk("bp_ksr", ksr_bp, 0);
    chk("bp_hold", hold_bad, 0);
    chk("bp_nct", nct, 8);
    chk("bp_w0", 32'(ctw[0]), 32'h5A);
    chk("bp_w1", 32'(ctw[1]), 32'hA5);
    chk("bp_w7", 32'(ctw[7]), 32'hA5);
    chk("bp_done", ndone, 1);

    run(20, 64'hFF00FF00FF00FF00, 24, 8'h00,
        0, 60, -1, 0);
    chk("rem_acc", nacc, 16);
    chk("rem_nct", nct, 2);
    chk("rem_w0", 32'(ctw[0]), 32'h00);
    chk("rem_w1", 32'(ctw[1]), 32'hFF);
    chk("rem_done", ndone, 1);

    run(32, 64'hFFFF_FFFF_FFFF_FFFF, 64, 8'h00,
        0, 100, -1, 2);
    chk("mid_nct", nct, 2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_quiet("mid");
    idle_inputs();
    reset = 1'b1;
    run(8, 64'h4D, 8, 8'hFF, 0, 30, -1, 0);
    chk("post_nct", nct, 1);
    chk("post_ct", 32'(ctw[0]), 32'(BASIC_CT));
    chk("post_done", ndone, 1);

    run(16, 64'hFF00FF00FF00FF00, 64, 8'h00,
        0, 60, 5, 0);
    chk("ign_acc", nacc, 16);
    chk("ign_nct", nct, 2);
    chk("ign_done", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trivium_xor_stage.md
Name: trivium_xor_stage

Overview:
- Downstream consumer of the Trivium keystream generator (ENCRIPT).
- Accepts one keystream bit per handshake and packs bits into W-bit words, buffered in a small FIFO.
- XORs each buffered word with a plaintext word and emits a ciphertext word over a valid/ready interface.
- Runs for a programmed bit length, then signals done.

Parameters:
- W, 8: keystream/plaintext/ciphertext word width.
- DEPTH, 4: keystream word FIFO depth (power of two, ≥2).
- LENW, 16: width of the length input, in bits.

Ports:
- clk, input, 1: single system clock, rising edge.
- reset, input, 1: synchronous, active-low reset.
- start, input, 1: one-cycle pulse; latches len and begins a run.
- len, input, LENW: run length in keystream bits; n_words = len / W, remainder discarded.
- ks_bit, input, 1: keystream bit from generator.
- ks_valid, input, 1: ks_bit valid.
- ks_ready, output, 1: stage accepts ks_bit this cycle.
- pt_data, input, W: plaintext word.
- pt_valid, input, 1: pt_data valid.
- pt_ready, output, 1: plaintext word accepted this cycle.
- ct_data, output, W: ciphertext word.
- ct_valid, output, 1: ct_data valid.
- ct_ready, input, 1: sink accepts ct_data.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse at end of run.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; all counters, FIFO pointers and pack register cleared.
  - ct_data=0, ct_valid=0, ks_ready=0, pt_ready=0, busy=0, done=0.
  - Reset asserted mid-run aborts the run immediately; any buffered words are discarded.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 latches n_words and goes to RUN. If n_words==0, go to DONE instead.
  - RUN: go to DONE on the ct handshake of word n_words-1.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored outside IDLE.
- Keystream side:
  - A bit transfers when ks_valid && ks_ready.
  - ks_ready = RUN && bits_taken < n_words*W && !(pack_cnt==W-1 && fifo_full).
  - Packing is MSB-first: the first bit lands in bit W-1.
  - When the W-th bit transfers, the completed word is pushed into the FIFO; it is visible as FIFO head on the next cycle. pack_cnt wraps to 0.
- Plaintext/ciphertext side:
  - pt_ready = RUN && !fifo_empty && (!ct_valid || ct_ready).
  - On pt_valid && pt_ready: the FIFO is popped, and ct_data <= pt_data XOR fifo_head with ct_valid <= 1 on the next edge.
  - ct_data is held stable while ct_valid && !ct_ready.
  - ct_valid clears after a handshake if no new plaintext word is accepted in the same cycle.
  - A FIFO push and pop in the same cycle are both performed; the count is unchanged.
- Latency: W-th keystream bit accepted at cycle t → pt accept possible at t+1 → ct_valid at t+2.
- Counters:
  - bits_taken is LENW+1 wide.
  - out_cnt counts ct handshakes and cannot wrap within a run, because n_words ≤ 2^LENW/W.

Optional Feature:
- Macro: TRIV_XOR_LSB_FIRST_EN.
  - Defined: packing is LSB-first; the first keystream bit lands in bit 0.
  - Undefined: MSB-first as specified above.
  - All other timing is identical in both builds.

Test Plan:
- Basic word: start with len=8; ks bits 1,0,1,1,0,0,1,0 → packed word 0xB2. pt_data=0xFF → ct_data=0x4D, then done pulse. With TRIV_XOR_LSB_FIRST_EN, packed word is 0x4D and ct_data=0xB2.
- Zero length: start with len=0 → ks_ready stays 0; done=1 for one cycle within 2 cycles of start; busy never asserts.
- Backpressure: len=64, ks_valid=1, pt_valid=1, ct_ready=0 → exactly 47 bits accepted (8 into the ct register, 32 into the FIFO, 7 in the pack register), then ks_ready=0. ct_data is stable. Raising ct_ready drains all 8 words, then done.
- Remainder: len=20 → exactly 16 ks bits accepted, 2 ct words, then done. ks_ready stays 0 after bit 16.
- Reset mid-run: len=32; after 2 ct words, drive reset=0 for one cycle → all outputs 0 and state IDLE. A new start with len=8 produces a correct single word, uncontaminated by old data.
- Start ignored: a start pulse during RUN with a different len → the current run completes with its original n_words.
